adc_udp_packetizer: RTL
=======================

Name: adc_udp_packetizer

Overview:
- Sits directly upstream of the UDP TX top and drives its udp_tx_valid/udp_tx_data byte stream, honouring udp_tx_busy.
- Collects ADC samples into ping-pong banks and emits one UDP payload per full bank.
- Each payload carries a 4-byte sequence number followed by the samples.
- Runs entirely in the 125 MHz transmit clock domain; samples arrive already synchronised to it.

Parameters:
- SAMPLES_PER_PKT, 256, samples per payload; power of two, 4..512.
- SAMPLE_W, 14, ADC sample width, 8..16; zero-extended to 16 bits on the wire.
- IPG_CYCLES, 16, minimum idle cycles between the end of one payload and the next start check; 1..255.

Ports:
- clk_125m  in  1  system clock, 125 MHz.
- rst_b  in  1  asynchronous, active-low reset.
- enable  in  1  capture enable.
- sample_valid  in  1  qualifies sample_data for one cycle.
- sample_data  in  SAMPLE_W  ADC sample.
- udp_tx_busy  in  1  downstream UDP generator busy.
- udp_tx_valid  out  1  payload byte valid; held high contiguously for the whole payload.
- udp_tx_data  out  8  payload byte.
- seq_num  out  32  sequence number of the next payload to send.
- overflow  out  1  sticky flag: at least one sample was dropped.

Behaviour:
- Reset (async assert, sync release):
  - Outputs: udp_tx_valid=0, udp_tx_data=0, seq_num=0, overflow=0.
  - Internal: both banks marked empty, write bank=0, write index=0, FSM=IDLE.
  - Reset asserted mid-payload drops udp_tx_valid immediately; the truncated packet is accepted.
- Payload format: 4+2*SAMPLES_PER_PKT bytes.
  - First 4 bytes: seq_num, big-endian (MSB first).
  - Then samples in arrival order, each as a 16-bit big-endian value with zero-extended MSBs.
- Writer:
  - Writes on sample_valid&&enable when the current write bank is empty-or-filling; the write index increments.
  - On the write at index SAMPLES_PER_PKT-1: that bank is marked full, index wraps to 0, and the writer switches to the other bank.
  - If the current write bank is full (reader has not yet released it): the sample is dropped and overflow is set to 1. overflow is cleared only by reset.
  - enable low: samples are ignored and the write index of the current filling bank resets to 0 (partial data discarded). Full banks are unaffected.
- Reader FSM:
  - IDLE: go to HDR when the read bank is full && udp_tx_busy==0.
  - HDR: 4 cycles, udp_tx_valid=1, emits seq_num bytes 3..0.
  - PAYLOAD: 2*SAMPLES_PER_PKT cycles, udp_tx_valid=1, samples high byte then low byte. Bank RAM has 1-cycle read latency; prefetch during HDR so there are no gaps.
  - After the final payload byte:
    - udp_tx_valid=0 the next cycle.
    - The read bank is marked empty.
    - The read bank toggles.
    - seq_num increments, wrapping 0xFFFFFFFF→0.
    - FSM goes to GAP.
  - GAP: count IPG_CYCLES cycles, then go to IDLE.
- Latency: with udp_tx_busy low, first udp_tx_valid occurs 2 cycles after the cycle in which the bank became full.
- udp_tx_busy is sampled only in IDLE. Once HDR starts, the payload runs to completion regardless of busy.
- Simultaneous events:
  - Writer marking a bank full in the same cycle the reader releases the other bank: both take effect.
  - Writer targeting a bank in the same cycle it is released: the bank is treated as empty and the write succeeds.
- udp_tx_data is registered. Its value when udp_tx_valid=0 is the last byte sent (0 after reset).

Optional Feature:
- Macro: ADC_PKT_TEST_PATTERN_EN.
- Defined:
  - Adds input port test_mode (1 bit).
  - When test_mode=1, each accepted sample is replaced by a 16-bit free-running counter. The counter starts at 0 after reset and increments per accepted sample, including samples accepted while test_mode=0.
  - Overflow and enable rules are unchanged.
- Undefined: no test_mode port and no counter logic; samples pass through unchanged.

Test Plan:
- SAMPLES_PER_PKT=4, enable=1, busy=0, feed 4 samples 0x0123,0x0456,0x0789,0x0ABC -> one 12-byte contiguous burst 00 00 00 00 01 23 04 56 07 89 0A BC; seq_num becomes 1.
- SAMPLE_W=14, sample 0x3FFF -> bytes 3F FF; sample 0x2001 -> 20 01 (MSBs zero).
- Hold busy=1 while 2 banks fill, then feed 1 more sample -> no udp_tx_valid while busy; overflow=1; on busy=0, two payloads with seq 0 and 1, separated by ≥IPG_CYCLES idle cycles.
- Feed 2 samples, drop enable for 1 cycle, feed 4 more -> only the last 4 samples appear in the payload.
- Assert rst_b low mid-PAYLOAD -> udp_tx_valid=0 immediately; after release, seq_num=0, overflow=0, next payload starts fresh.
- With ADC_PKT_TEST_PATTERN_EN and test_mode=1, SAMPLES_PER_PKT=4 -> first two payloads carry 0000,0001,0002,0003 then 0004..0007.

Source files
------------

// File: rtl/adc_udp_packetizer.sv
// rtl/adc_udp_packetizer.sv - ping-pong ADC sample banks framed as seq-numbered UDP payload bytes
// Optional test-pattern sample source: define ADC_PKT_TEST_PATTERN_EN.
module adc_udp_packetizer #(
  parameter int SAMPLES_PER_PKT = 256,
  parameter int SAMPLE_W        = 14,
  parameter int IPG_CYCLES      = 16
) (
  input  logic                clk_125m,
  input  logic                rst_b,
  input  logic                enable,
  input  logic                sample_valid,
  input  logic [SAMPLE_W-1:0] sample_data,
  input  logic                udp_tx_busy,
`ifdef ADC_PKT_TEST_PATTERN_EN
  input  logic                test_mode,
`endif
  output logic                udp_tx_valid,
  output logic [7:0]          udp_tx_data,
  output logic [31:0]         seq_num,
  output logic                overflow
);

  localparam int IDX_W = $clog2(SAMPLES_PER_PKT);
  localparam int CNT_W = 16;
  localparam logic [CNT_W-1:0] HDR_LAST = CNT_W'(3);
  localparam logic [CNT_W-1:0] PAY_LAST = CNT_W'(2 * SAMPLES_PER_PKT - 1);
  localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'(IPG_CYCLES - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(SAMPLES_PER_PKT - 1);

  typedef enum logic [1:0] {S_IDLE, S_HDR, S_PAYLOAD, S_GAP} state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             valid_q, valid_d;
  logic [7:0]       data_q, data_d;
  logic [31:0]      seq_q, seq_d;
  logic             overflow_q, overflow_d;
  logic [1:0]       full_q, full_d;
  logic             wr_bank_q, wr_bank_d;
  logic [IDX_W-1:0] wr_idx_q, wr_idx_d;
  logic             rd_bank_q, rd_bank_d;
  logic [15:0]      rd_data_q;

  logic             start;
  logic             rel;
  logic             wr_hit;
  logic             accept;
  logic [15:0]      wr_word;
  logic [IDX_W-1:0] rd_idx;
  logic [IDX_W:0]   wr_addr;
  logic [IDX_W:0]   rd_addr;

  logic [15:0] bank_mem [0:2*SAMPLES_PER_PKT-1];

`ifdef ADC_PKT_TEST_PATTERN_EN
  logic [15:0] pat_cnt_q, pat_cnt_d;
  assign wr_word   = test_mode ? pat_cnt_q : 16'(sample_data);
  assign pat_cnt_d = accept ? pat_cnt_q + 16'd1 : pat_cnt_q;
`else
  assign wr_word   = 16'(sample_data);
`endif

  assign start  = (state_q == S_IDLE) && full_q[rd_bank_q] && !udp_tx_busy;
  assign rel    = (state_q == S_PAYLOAD) && (cnt_q == PAY_LAST);
  assign wr_hit = sample_valid && enable;
  // A bank released this cycle counts as empty for the writer.
  assign accept = wr_hit && (!full_q[wr_bank_q] || (rel && (rd_bank_q == wr_bank_q)));

  // Address runs one sample ahead of the byte on the wire to hide RAM latency.
  assign rd_idx  = (state_q == S_PAYLOAD) ? cnt_q[IDX_W:1] + IDX_W'(1) : '0;
  assign rd_addr = {rd_bank_q, rd_idx};
  assign wr_addr = {wr_bank_q, wr_idx_q};

  always_ff @(posedge clk_125m) begin
    if (accept) begin
      bank_mem[wr_addr] <= wr_word;
    end
    rd_data_q <= bank_mem[rd_addr];
  end

  always_ff @(posedge clk_125m or negedge rst_b) begin
    if (!rst_b) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:    if (start) state_d = S_HDR;
      S_HDR:     if (cnt_q == HDR_LAST) state_d = S_PAYLOAD;
      S_PAYLOAD: if (cnt_q == PAY_LAST) state_d = S_GAP;
      S_GAP:     if (cnt_q == GAP_LAST) state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  // Outputs are registered, so each cycle prepares the byte for the next one.
  always_comb begin
    valid_d = 1'b0;
    data_d  = data_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          valid_d = 1'b1;
          data_d  = seq_q[31:24];
        end
      end
      S_HDR: begin
        valid_d = 1'b1;
        case (cnt_q[1:0])
          2'd0:    data_d = seq_q[23:16];
          2'd1:    data_d = seq_q[15:8];
          2'd2:    data_d = seq_q[7:0];
          default: data_d = rd_data_q[15:8];
        endcase
      end
      S_PAYLOAD: begin
        if (!rel) begin
          valid_d = 1'b1;
          data_d  = cnt_q[0] ? rd_data_q[15:8] : rd_data_q[7:0];
        end
      end
      default: begin
        valid_d = 1'b0;
      end
    endcase
  end

  always_comb begin
    cnt_d      = (state_d != state_q || state_q == S_IDLE) ? '0 : cnt_q + CNT_W'(1);
    seq_d      = rel ? seq_q + 32'd1 : seq_q;
    rd_bank_d  = rel ? ~rd_bank_q : rd_bank_q;
    full_d     = full_q;
    wr_bank_d  = wr_bank_q;
    wr_idx_d   = wr_idx_q;
    overflow_d = overflow_q;
    if (rel) begin
      full_d[rd_bank_q] = 1'b0;
    end
    if (!enable) begin
      wr_idx_d = '0;
    end else if (accept) begin
      if (wr_idx_q == IDX_LAST) begin
        full_d[wr_bank_q] = 1'b1;
        wr_idx_d          = '0;
        wr_bank_d         = ~wr_bank_q;
      end else begin
        wr_idx_d = wr_idx_q + IDX_W'(1);
      end
    end else if (wr_hit) begin
      overflow_d = 1'b1;
    end
  end

  always_ff @(posedge clk_125m or negedge rst_b) begin
    if (!rst_b) begin
      cnt_q      <= '0;
      valid_q    <= 1'b0;
      data_q     <= 8'd0;
      seq_q      <= 32'd0;
      overflow_q <= 1'b0;
      full_q     <= 2'b00;
      wr_bank_q  <= 1'b0;
      wr_idx_q   <= '0;
      rd_bank_q  <= 1'b0;
`ifdef ADC_PKT_TEST_PATTERN_EN
      pat_cnt_q  <= 16'd0;
`endif
    end else begin
      cnt_q      <= cnt_d;
      valid_q    <= valid_d;
      data_q     <= data_d;
      seq_q      <= seq_d;
      overflow_q <= overflow_d;
      full_q     <= full_d;
      wr_bank_q  <= wr_bank_d;
      wr_idx_q   <= wr_idx_d;
      rd_bank_q  <= rd_bank_d;
`ifdef ADC_PKT_TEST_PATTERN_EN
      pat_cnt_q  <= pat_cnt_d;
`endif
    end
  end

  assign udp_tx_valid = valid_q;
  assign udp_tx_data  = data_q;
  assign seq_num      = seq_q;
  assign overflow     = overflow_q;

endmodule
